// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the ROM load engine.
//   state_t   - loader FSM states
//   ERR_*     - err_code values reported on the error output
//   ROM_DEPTH - word depth of each target ROM
package rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD        = 3'd1,
    S_VERIFY_ADDR = 3'd2,
    S_VERIFY_CMP  = 3'd3,
    S_DONE        = 3'd4,
    S_ERROR       = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  localparam int unsigned ROM_DEPTH = 64;

endpackage

// File: rtl/rom_loader_csum.sv
// rom_csum_acc: modular checksum accumulator (wraps at 2^W).
//   clk, rst   - clock, synchronous active-low reset
//   clr        - clear sum (priority over en)
//   en, add    - accumulate add into sum
//   sum        - registered running sum
//   sum_next   - sum + add, for same-cycle comparisons
module rom_csum_acc #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] sum,
  output logic [W-1:0] sum_next
);

  assign sum_next = sum + add;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: streams an image into PMEM/EMEM over the ROM load port, reads it
// back to confirm a checksum, and holds the CPU in reset until that succeeds.
//   sys_clk, sys_rst         - clock, synchronous active-low reset
//   start, image_sel,
//   word_count               - load request (sel/count latched on start)
//   in_valid, in_data,
//   in_ready                 - image word stream
//   rom_we, rom_select,
//   rom_addr, rom_wd         - registered ROM write/address port
//   rom_rd                   - ROM readback data
//   cpu_rst_hold             - 1 keeps the CPU in reset
//   busy, done, error,
//   err_code                 - status
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              image_sel,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic              rom_select,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wd,
  input  logic [DATA_W-1:0] rom_rd,
  output logic              cpu_rst_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state, state_n;
  logic [ADDR_W:0]   idx, idx_n, idx_inc;
  logic [ADDR_W:0]   count, count_n;
  logic              sel_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wd_n;
  logic [1:0]        err_n;
  logic              accept;
  logic              wclr, wen, rclr, ren;
  logic [DATA_W-1:0] wsum, wsum_next, rsum, rsum_next;

  rom_csum_acc #(.W(DATA_W)) u_wsum (
    .clk(sys_clk), .rst(sys_rst), .clr(wclr), .en(wen),
    .add(in_data), .sum(wsum), .sum_next(wsum_next)
  );

  rom_csum_acc #(.W(DATA_W)) u_rsum (
    .clk(sys_clk), .rst(sys_rst), .clr(rclr), .en(ren),
    .add(rom_rd), .sum(rsum), .sum_next(rsum_next)
  );

  assign idx_inc      = idx + 1'b1;
  assign busy         = (state == S_LOAD) || (state == S_VERIFY_ADDR) ||
                        (state == S_VERIFY_CMP);
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERROR);
  assign cpu_rst_hold = (state != S_DONE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      count      <= '0;
      rom_select <= 1'b0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wd     <= '0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      count      <= count_n;
      rom_select <= sel_n;
      rom_we     <= we_n;
      rom_addr   <= addr_n;
      rom_wd     <= wd_n;
      err_code   <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    count_n  = count;
    sel_n    = rom_select;
    we_n     = 1'b0;
    addr_n   = rom_addr;
    wd_n     = rom_wd;
    err_n    = err_code;
    wclr     = 1'b0;
    wen      = 1'b0;
    rclr     = 1'b0;
    ren      = 1'b0;
    in_ready = (state == S_LOAD) && (idx < count);
    accept   = in_valid && in_ready;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if ((word_count == '0) || (word_count > DEPTH)) begin
            state_n = S_ERROR;
            err_n   = ERR_COUNT;
          end else begin
            state_n = S_LOAD;
            count_n = word_count;
            sel_n   = image_sel;
            idx_n   = '0;
            wclr    = 1'b1;
            rclr    = 1'b1;
            err_n   = ERR_NONE;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_n   = 1'b1;
          addr_n = idx[ADDR_W-1:0];
          wd_n   = in_data;
          wen    = 1'b1;
          idx_n  = idx_inc;
        end else if (idx == count) begin
          // Final write is on the bus this cycle; the readback address is
          // set up here so it is already idx during VERIFY_ADDR.
          idx_n   = '0;
          addr_n  = '0;
          state_n = S_VERIFY_ADDR;
        end
      end
      S_VERIFY_ADDR: begin
        state_n = S_VERIFY_CMP;
      end
      S_VERIFY_CMP: begin
        // Address has been stable for two cycles, so rom_rd is good for
        // both combinational and one-cycle-registered ROMs.
        ren = 1'b1;
        if (idx == count - 1'b1) begin
          if (rsum_next == wsum) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ERROR;
            err_n   = ERR_CSUM;
          end
        end else begin
          idx_n   = idx_inc;
          addr_n  = idx_inc[ADDR_W-1:0];
          state_n = S_VERIFY_ADDR;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          start = 1'b0;
  logic          image_sel = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          rom_we;
  logic          rom_select;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_wd;
  logic [DW-1:0] rom_rd;
  logic          cpu_rst_hold, busy, done, error;
  logic [1:0]    err_code;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;

  logic [DW-1:0] mem [2][64];
  logic [DW-1:0] img [64];
  bit            corrupt = 1'b0;
  bit            mon_en = 1'b0;
  logic [AW+DW:0] exp_q [$];
  int unsigned   nwr = 0, vcyc = 0, wrun = 0, wrun_max = 0;

  always #5 sys_clk = ~sys_clk;

  rom_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .image_sel(image_sel), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rom_we(rom_we), .rom_select(rom_select), .rom_addr(rom_addr),
    .rom_wd(rom_wd), .rom_rd(rom_rd), .cpu_rst_hold(cpu_rst_hold),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  // Behavioural ROM pair; address 2 can be made to read back with bit 0 flipped.
  always @(posedge sys_clk) if (rom_we) mem[rom_select][rom_addr] <= rom_wd;
  assign rom_rd = mem[rom_select][rom_addr] ^
                  ((corrupt && rom_addr == 6'd2) ? 32'h1 : 32'h0);

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (!busy) check("in_ready_idle", in_ready, 0);
      if (busy && !in_ready && !rom_we) vcyc++;
      if (rom_we) begin
        nwr++;
        wrun++;
        if (wrun > wrun_max) wrun_max = wrun;
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("write", {rom_select, rom_addr, rom_wd}, exp_q.pop_front());
      end else begin
        wrun = 0;
      end
    end
  end

  task automatic run_load(input bit sel, input int unsigned cnt, input int mode,
                          input bit corr, input int unsigned abort_at,
                          input bit mid_start);
    logic [DW-1:0] ws, rs;
    int unsigned   k, nwr0, t;
    bit            acc, exp_ok;
    corrupt  = corr;
    vcyc     = 0;
    wrun_max = 0;
    nwr0     = nwr;
    image_sel  = sel;
    word_count = (AW+1)'(cnt);
    start      = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    k = 0;
    for (int cyc = 0; cyc < 1000 && k < cnt; cyc++) begin
      if (mid_start) begin
        start      = (cyc == 3);
        word_count = 7'd5;
        image_sel  = ~sel;
      end
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = cyc[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = img[k];
      acc = in_valid && in_ready;
      @(posedge sys_clk); #1;
      if (acc) begin
        exp_q.push_back({sel, 6'(k), img[k]});
        k++;
      end
      if (abort_at != 0 && k == abort_at) begin
        in_valid = 1'b0;
        start    = 1'b0;
        sys_rst  = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        check("abort_rom_we", rom_we, 0);
        check("abort_busy", busy, 0);
        check("abort_hold", cpu_rst_hold, 1);
        check("abort_done", done, 0);
        check("abort_error", error, 0);
        check("abort_err_code", err_code, 0);
        check("abort_writes", nwr - nwr0, abort_at);
        check("abort_queue", exp_q.size(), 0);
        return;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("words_accepted", k, cnt);
    t = 0;
    while (!(done || error) && t < 400) begin
      @(posedge sys_clk); #1;
      t++;
    end
    check("finish_in_time", done || error, 1);
    ws = '0;
    rs = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      ws += img[i];
      rs += img[i] ^ ((corr && i == 2) ? 32'h1 : 32'h0);
    end
    exp_ok = (ws == rs);
    check("done", done, exp_ok);
    check("error", error, !exp_ok);
    check("err_code", err_code, exp_ok ? 0 : 2);
    check("cpu_rst_hold", cpu_rst_hold, !exp_ok);
    check("write_count", nwr - nwr0, cnt);
    check("queue_drained", exp_q.size(), 0);
    check("verify_cycles", vcyc, 2 * cnt);
    check("rom_select_hold", rom_select, sel);
    if (mode == 0) check("b2b_run", wrun_max, cnt);
  endtask

  task automatic bad_count(input int unsigned cnt);
    int unsigned nwr0;
    nwr0       = nwr;
    word_count = (AW+1)'(cnt);
    start      = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("badcnt_error", error, 1);
    check("badcnt_err_code", err_code, 1);
    check("badcnt_busy", busy, 0);
    check("badcnt_done", done, 0);
    check("badcnt_hold", cpu_rst_hold, 1);
    repeat (3) begin @(posedge sys_clk); #1; end
    check("badcnt_writes", nwr - nwr0, 0);
    check("badcnt_error_held", error, 1);
  endtask

  initial begin
    int unsigned nwr0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 64; a++) mem[s][a] = '0;

    repeat (2) @(posedge sys_clk);
    #1;
    mon_en = 1'b1;
    check("rst_rom_we", rom_we, 0);
    check("rst_rom_select", rom_select, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_wd", rom_wd, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_hold", cpu_rst_hold, 1);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 64; i++) img[i] = $urandom;
    run_load(1'b0, 8, 0, 1'b0, 3, 1'b0);

    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
    run_load(1'b0, 4, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 64; i++) img[i] = '1;
    run_load(1'b1, 64, 1, 1'b0, 0, 1'b0);

    bad_count(0);
    bad_count(65);

    for (int i = 0; i < 64; i++) img[i] = $urandom;
    run_load(1'b0, 4, 2, 1'b1, 0, 1'b0);
    run_load(1'b0, 4, 2, 1'b0, 0, 1'b0);

    run_load(1'b1, 8, 0, 1'b0, 0, 1'b1);
    nwr0     = nwr;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (6) begin @(posedge sys_clk); #1; end
    in_valid = 1'b0;
    check("done_valid_writes", nwr - nwr0, 0);
    check("done_valid_done", done, 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) img[i] = $urandom;
      run_load(1'($urandom_range(0, 1)), $urandom_range(1, 64), 2,
               1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Initiator-side engine for the SoC ROM load port (rom_we / rom_select / rom_addr / rom_wd / rom_rd).
- Accepts an image as a valid/ready word stream and writes it into PMEM or EMEM. Then reads the image back and checks it with a checksum.
- Holds the MIPS core in reset until the load verifies. Replaces testbench-driven ROM loading at the top level.

Parameters:
- ADDR_W, 6, ROM word-address width (depth 2^ADDR_W = 64 words)
- DATA_W, 32, ROM word width

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-low reset
- start  in  1  begin load; sampled in IDLE, DONE, ERROR only
- image_sel  in  1  target ROM; 0 = PMEM, 1 = EMEM; latched on start
- word_count  in  ADDR_W+1  number of words to load (1..64); latched on start
- in_valid  in  1  stream word valid
- in_data  in  DATA_W  stream word
- in_ready  out  1  loader accepts a word this cycle
- rom_we  out  1  ROM write enable (registered)
- rom_select  out  1  ROM select (registered)
- rom_addr  out  ADDR_W  ROM word address (registered)
- rom_wd  out  DATA_W  ROM write data (registered)
- rom_rd  in  DATA_W  ROM readback data
- cpu_rst_hold  out  1  1 = hold MIPS in reset
- busy  out  1  in LOAD / VERIFY_ADDR / VERIFY_CMP
- done  out  1  level; load verified
- error  out  1  level; load failed
- err_code  out  2  0 none, 1 bad word_count, 2 checksum mismatch

Behaviour:
- Reset (sys_rst == 0 at a sys_clk edge):
  - state goes to IDLE; all counters and sums clear.
  - Outputs: rom_we=0, rom_select=0, rom_addr=0, rom_wd=0, in_ready=0, busy=0, done=0, error=0, err_code=0, cpu_rst_hold=1.
  - Reset mid-operation aborts immediately. A partial image may remain in the ROM. No write is issued in the cycle after reset.
- States: IDLE, LOAD, VERIFY_ADDR, VERIFY_CMP, DONE, ERROR.
- Start from IDLE, DONE or ERROR, when start == 1:
  - If word_count == 0 or word_count > 64: go to ERROR with err_code=1.
  - Otherwise: latch image_sel and word_count, clear idx, wsum and rsum, set cpu_rst_hold=1, clear done/error, and go to LOAD.
  - start is ignored while busy.
- LOAD:
  - in_ready = 1 combinationally while in LOAD and idx < count.
  - Word accepted at edge t (in_valid & in_ready): at t+1 the outputs are rom_we=1, rom_addr=idx, rom_wd=in_data, rom_select=sel.
  - Also on acceptance: wsum += in_data (mod 2^32), idx += 1.
  - With no acceptance, rom_we=0 the next cycle.
  - After the count-th acceptance: in_ready drops, the final write issues next cycle, then idx clears and state goes to VERIFY_ADDR.
- VERIFY_ADDR:
  - rom_addr=idx, rom_we=0; go to VERIFY_CMP.
- VERIFY_CMP:
  - rom_addr held; rsum += rom_rd, valid for both combinational and 1-cycle-registered ROM read.
  - If idx == count-1: go to DONE when rsum_next == wsum, else ERROR with err_code=2.
  - Otherwise idx += 1 and return to VERIFY_ADDR. Verify therefore takes 2*count cycles.
- DONE: done=1, cpu_rst_hold=0. Held until the next start or reset.
- ERROR: error=1, cpu_rst_hold=1. Held until the next start or reset.
- rom_select stays at the latched sel throughout an operation and holds its last value in DONE/ERROR.
- Address wrap: idx never exceeds count-1. For count=64, address 63 is the last write and no wrap occurs.
- in_valid while not in LOAD is ignored (in_ready=0). in_data is not consumed.

Decomposition:
- Package rom_loader_pkg:
  - state encoding localparams (3-bit)
  - err_code constants ERR_NONE, ERR_COUNT, ERR_CSUM
  - ROM_DEPTH = 64
- No sub-module is required. The checksum accumulator may be factored as rom_csum_acc (clear / enable / add, 32-bit wrap) and instantiated twice, for wsum and rsum.

Test Plan:
- Reset mid-LOAD (sys_rst low for 1 cycle after word 3 of 8) -> next cycle state IDLE, rom_we=0, cpu_rst_hold=1, done=0, error=0, err_code=0.
- start, sel=0, count=4, words 0x11,0x22,0x33,0x44 streamed back-to-back -> rom_we high 4 consecutive cycles at addr 0..3 with rom_select=0; verify takes 8 cycles; done=1, cpu_rst_hold=0, err_code=0.
- sel=1, count=64, in_valid toggling every other cycle with 0xFFFFFFFF words -> 64 writes to EMEM at addr 0..63, none lost; checksum wraps to 0xFFFFFFC0; done=1.
- count=0, then separately count=65 -> ERROR next cycle, err_code=1, no rom_we pulse, in_ready never asserted.
- Model ROM corrupts addr 2 (readback bit flip) on a count=4 load -> error=1, err_code=2, cpu_rst_hold stays 1; a second start with a good ROM then reaches done=1.
- start pulsed during LOAD, and in_valid held high in DONE -> both ignored; write count is unchanged and in_ready stays 0 outside LOAD.
